tc_serial_decoder: RTL and testbench
====================================

Name: tc_serial_decoder

Overview:
- Bit-serial two's-complement to sign-magnitude decoder; the inverse of the team's combinational 5-bit two's-complement negator.
- Accepts a WIDTH-bit two's-complement word over a valid/ready handshake.
- Converts the word LSB-first, one bit per clock, using copy-until-first-1-then-invert; the sign alone selects whether inversion applies.
- Presents the sign and the unsigned magnitude on a valid/ready output port; sits between the arithmetic datapath and display/compare logic that needs sign-magnitude.

Parameters:
- WIDTH, 5, operand width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  two's-complement operand.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- out_sign  output  1  1 = negative.
- out_mag  output  WIDTH  unsigned magnitude.

Behaviour:
- Reset (async, rst=1), all outputs:
  - state=IDLE, in_ready=1, out_valid=0, out_sign=0, out_mag=0.
  - Internal shift register, bit counter and seen_one flag all cleared.
- Reset asserted mid-conversion aborts the word: no output is produced and the block returns to IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a clock edge:
    - latch in_data into the shift register;
    - out_sign <= in_data[WIDTH-1];
    - cnt <= 0, seen_one <= 0, out_mag <= 0;
    - go to SHIFT.
- SHIFT:
  - in_ready=0, out_valid=0.
  - Each cycle, process b = sr[0]:
    - if sign=0, mag bit = b;
    - if sign=1, mag bit = seen_one ? ~b : b, then seen_one <= seen_one | b.
  - The mag bit shifts into out_mag from the MSB side; sr shifts right; cnt++.
  - After WIDTH bits (cnt==WIDTH-1 processed), go to DONE.
- DONE:
  - out_valid=1; out_sign and out_mag held stable while out_ready=0.
  - On out_ready=1 go to IDLE at that edge. in_ready rises on the next cycle; there is no same-cycle accept from DONE.
- Latency:
  - Accept edge to out_valid = WIDTH+1 cycles.
  - Throughput = one word per WIDTH+2 cycles with out_ready held high.
- Arithmetic:
  - Zero -> sign 0, mag 0.
  - Most negative value (1 followed by zeros) -> sign 1, mag = 2^(WIDTH-1). This fits in WIDTH unsigned bits, so there is no overflow.
- in_valid while busy is ignored; the upstream holds its data per the handshake.

Optional Feature:
- TC_DECODE_FASTPOS_EN
- Defined: a non-negative operand (in_data[WIDTH-1]=0) bypasses SHIFT.
  - out_mag <= in_data and state goes to DONE at the accept edge.
  - out_valid is asserted the next cycle, i.e. latency 1.
  - Negative operands are unchanged.
- Undefined: every operand takes the full WIDTH-cycle serial path.

Decomposition:
- Shared package tc_pkg holds:
  - state enum {IDLE, SHIFT, DONE} (2-bit encoding);
  - TC_WIDTH_DEF=5;
  - counter-width constant $clog2(WIDTH+1).
- One sub-module, tc_serial_cell: combinational per-bit transform (inputs b, sign, seen_one; outputs mag_bit, seen_one_next). The seen_one flop stays in the parent.

Test Plan:
- Reset mid-SHIFT: accept 5'b11010, assert rst 2 cycles later -> out_valid stays 0, in_ready=1 after release, and a following 5'b00011 decodes correctly.
- Negative, WIDTH=5: accept 5'b11010 -> out_valid exactly 6 cycles after the accept edge, sign=1, mag=5'b00110.
- Positive, out_ready held low: accept 5'b00101 -> sign=0, mag=5'b00101.
  - Hold out_ready=0 for 4 cycles -> outputs stable and in_ready=0.
  - Raise out_ready -> in_ready=1 on the next cycle.
- Boundaries: 5'b00000 -> sign 0, mag 0. 5'b10000 -> sign 1, mag 5'b10000. 5'b11111 -> sign 1, mag 5'b00001. 5'b01111 -> sign 0, mag 5'b01111.
- Back-to-back stream (out_ready=1, in_valid=1): words 5'b11011, 5'b00011, 5'b10101 -> results (1,00101), (0,00011), (1,01011), one per 7 cycles; busy-time in_data changes are ignored.
- With TC_DECODE_FASTPOS_EN: 5'b00101 -> out_valid 1 cycle after accept. 5'b11101 -> still 6 cycles, result (1,00011).

Source files
------------

// File: rtl/tc_pkg.sv
// Shared definitions for the bit-serial two's-complement to sign-magnitude decoder.
//   tc_state_e      : controller states (2-bit encoding)
//   TC_WIDTH_DEF    : default operand width
//   TC_CNT_W_DEF    : bit-counter width for the default operand width
//   tc_cnt_w()      : bit-counter width for an arbitrary operand width
package tc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } tc_state_e;

  localparam int TC_WIDTH_DEF = 5;
  localparam int TC_CNT_W_DEF = $clog2(TC_WIDTH_DEF + 1);

  // The counter only has to reach WIDTH-1, but sizing for WIDTH+1 values keeps
  // the width at least one bit for every legal WIDTH.
  function automatic int tc_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/tc_serial_cell.sv
// Per-bit transform for the copy-until-first-1-then-invert negation.
// Ports:
//   b_i             : current operand bit (LSB-first)
//   sign_i          : operand sign; only a negative operand is inverted
//   seen_one_i      : a 1 has already been seen in lower-order bits
//   mag_bit_o       : magnitude bit for this position
//   seen_one_next_o : updated seen-one flag (registered by the parent)
module tc_serial_cell (
  input  logic b_i,
  input  logic sign_i,
  input  logic seen_one_i,
  output logic mag_bit_o,
  output logic seen_one_next_o
);

  // Bits up to and including the first 1 pass through; every bit above it
  // is inverted. A positive operand passes through untouched.
  assign mag_bit_o       = (sign_i && seen_one_i) ? ~b_i : b_i;
  assign seen_one_next_o = sign_i ? (seen_one_i | b_i) : seen_one_i;

endmodule

// File: rtl/tc_serial_decoder.sv
// Bit-serial two's-complement to sign-magnitude decoder.
// Accepts a WIDTH-bit word over valid/ready, converts it LSB-first one bit
// per clock and presents sign + unsigned magnitude over valid/ready.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : input handshake; in_data is the two's-complement word
//   out_valid/out_ready  : output handshake; out_sign (1 = negative), out_mag
// Build option:
//   TC_DECODE_FASTPOS_EN : non-negative operands skip the serial pass and go
//                          straight to DONE at the accept edge.
//
// state | meaning
// IDLE  | waiting for a word, in_ready=1
// SHIFT | converting one bit per clock
// DONE  | result valid, held until out_ready
module tc_serial_decoder
  import tc_pkg::*;
#(
  parameter int WIDTH = TC_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag
);

  localparam int CW = tc_cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  tc_state_e        state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             seen_q, seen_d;
  logic             sign_q, sign_d;

  logic mag_bit;
  logic seen_next;

  tc_serial_cell u_cell (
    .b_i             (sr_q[0]),
    .sign_i          (sign_q),
    .seen_one_i      (seen_q),
    .mag_bit_o       (mag_bit),
    .seen_one_next_o (seen_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      mag_q   <= '0;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      sign_q  <= sign_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    sign_d  = sign_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sr_d    = in_data;
          sign_d  = in_data[WIDTH-1];
          cnt_d   = '0;
          seen_d  = 1'b0;
          mag_d   = '0;
          state_d = SHIFT;
`ifdef TC_DECODE_FASTPOS_EN
          // A non-negative word is already its own magnitude.
          if (!in_data[WIDTH-1]) begin
            mag_d   = in_data;
            state_d = DONE;
          end
`endif
        end
      end
      SHIFT: begin
        // Magnitude fills from the MSB side so bit 0 lands in place after WIDTH shifts.
        mag_d  = {mag_bit, mag_q[WIDTH-1:1]};
        sr_d   = {1'b0, sr_q[WIDTH-1:1]};
        seen_d = seen_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sign  = sign_q;
  assign out_mag   = mag_q;

endmodule

// File: tb/tb_tc_serial_decoder.sv
module tb_tc_serial_decoder;

  localparam int W = 5;
`ifdef TC_DECODE_FASTPOS_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_sign;
  logic [W-1:0] out_mag;

  int n_cmp = 0;
  int n_bad = 0;

  tc_serial_decoder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_mag   (out_mag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] din;
    logic         exp_s;
    logic [W-1:0] exp_m;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] d);
    return (FAST && !d[W-1]) ? 1 : W + 1;
  endfunction

  time acc_t;

  // Called just after a negedge. Waits for in_ready, offers d, and after the
  // accept edge counts negedge samples until out_valid appears.
  task automatic run_word(input string name, input logic [W-1:0] d,
                          input logic es, input logic [W-1:0] em,
                          input bit keep_valid);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_ready_wait"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    acc_t = $time;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        in_valid = keep_valid;
        in_data  = W'($urandom);
      end
    end while (!out_valid && n < 40);
    chk({name, "_latency"}, 32'(n), 32'(exp_lat(d)));
    chk({name, "_sign"}, 32'(out_sign), 32'(es));
    chk({name, "_mag"}, 32'(out_mag), 32'(em));
    chk({name, "_in_ready_busy"}, 32'(in_ready), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    time prev_t;
    vecs[0] = '{5'b00000, 1'b0, 5'b00000};
    vecs[1] = '{5'b10000, 1'b1, 5'b10000};
    vecs[2] = '{5'b11111, 1'b1, 5'b00001};
    vecs[3] = '{5'b01111, 1'b0, 5'b01111};
    vecs[4] = '{5'b11010, 1'b1, 5'b00110};
    vecs[5] = '{5'b00101, 1'b0, 5'b00101};
    vecs[6] = '{5'b01010, 1'b0, 5'b01010};
    vecs[7] = '{5'b10110, 1'b1, 5'b01010};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sign", 32'(out_sign), 32'd0);
    chk("rst_out_mag", 32'(out_mag), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      run_word($sformatf("vec%0d", i), vecs[i].din, vecs[i].exp_s, vecs[i].exp_m, 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d_release", i), 32'(in_ready), 32'd1);
    end

    // Reset in the middle of a conversion
    in_valid = 1'b1;
    in_data  = 5'b11010;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen_v;
      seen_v = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (out_valid) seen_v++;
      end
      chk("midrst_no_output", 32'(seen_v), 32'd0);
    end
    chk("midrst_in_ready_after", 32'(in_ready), 32'd1);
    run_word("post_rst", 5'b00011, 1'b0, 5'b00011, 1'b0);
    @(negedge clk);

    // Output stall: result must hold while out_ready is low
    out_ready = 1'b0;
    run_word("hold", 5'b00101, 1'b0, 5'b00101, 1'b0);
    begin
      int bad_hold;
      bad_hold = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (!out_valid || out_sign !== 1'b0 || out_mag !== 5'b00101 || in_ready !== 1'b0)
          bad_hold++;
      end
      chk("hold_stable_4cyc", 32'(bad_hold), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("hold_release_in_ready", 32'(in_ready), 32'd1);
    chk("hold_release_out_valid", 32'(out_valid), 32'd0);

    // Back-to-back stream with in_valid held and junk data while busy
    run_word("stream0", 5'b11011, 1'b1, 5'b00101, 1'b1);
    prev_t = acc_t;
    run_word("stream1", 5'b00011, 1'b0, 5'b00011, 1'b1);
    chk("stream1_spacing", 32'((acc_t - prev_t) / 10), 32'(exp_lat(5'b11011) + 1));
    prev_t = acc_t;
    run_word("stream2", 5'b10101, 1'b1, 5'b01011, 1'b1);
    chk("stream2_spacing", 32'((acc_t - prev_t) / 10), 32'(exp_lat(5'b00011) + 1));
    in_valid = 1'b0;

    // Negative operand always takes the serial path
    @(negedge clk);
    run_word("neg_serial", 5'b11101, 1'b1, 5'b00011, 1'b0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
